// File: rtl/disp_pkg.sv
// Shared display constants: active-low segment patterns (seg[0]=a .. seg[6]=g),
// anode select codes and the per-frame snapshot type.
package disp_pkg;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_LAST = 2'd3;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;
  // Element i drives anode i low.
  localparam logic [3:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct packed {
    logic [3:0][3:0] digits;   // digits[0] = ones .. digits[3] = thousands
    logic [3:0]      blink;
    logic [3:0]      dp;
    logic            blank_lz;
  } snap_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern; codes 10-15 show a dash.
module seg_decode
  import disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot,
// per-digit blink and decimal point, and leading-zero blanking of digit 3.
module seg_scan
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  slot_t         slot_q, slot_d;
  logic          phase_q, phase_d;
  snap_t         snap_q, snap_d;
  logic          init_q, init_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          presc_tc, blink_tc, blanked;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;

  seg_decode u_seg_decode (
    .code_i (cur_digit),
    .seg_o  (dec_seg)
  );

  always_comb begin
    presc_tc = (presc_q == PRESC_TC);
    blink_tc = (blink_q == BLINK_TC);

    presc_d = presc_tc ? '0 : presc_q + PW'(1);
    slot_d  = presc_tc ? slot_q + 2'd1 : slot_q;
    blink_d = blink_tc ? '0 : blink_q + BW'(1);
    phase_d = phase_q ^ blink_tc;
    init_d  = 1'b0;

    // Reload at the frame boundary, and once right after reset so the first
    // frame never shows the cleared snapshot.
    snap_d = snap_q;
    if (init_q || (slot_q == SLOT_LAST && presc_tc)) begin
      snap_d.digits   = {thousands, hundreds, tens, ones};
      snap_d.blink    = blink_mask;
      snap_d.dp       = dp_mask;
      snap_d.blank_lz = blank_lz;
    end

    cur_digit = snap_q.digits[slot_q];
    blanked   = init_q
              | (phase_q & snap_q.blink[slot_q])
              | ((slot_q == SLOT_LAST) & snap_q.blank_lz & (snap_q.digits[3] == 4'd0));

    an_d  = blanked ? AN_OFF  : AN_SEL[slot_q];
    seg_d = blanked ? SEG_OFF : dec_seg;
    dp_d  = ~(snap_q.dp[slot_q] & ~blanked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      blink_q <= '0;
      slot_q  <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      init_q  <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      init_q  <= init_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the four BCD digits (ones, tens, hundreds, thousands) produced by the digit-split stage and cycles through them at a fixed refresh rate. For each digit it drives active-low anode and segment lines, with per-digit blink, per-digit decimal point and optional leading-zero blanking. It is the last stage before the board pins.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit (slot length); minimum 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; minimum 2.

Ports (clock and reset first):
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high.
- ones  input  4  BCD digit 0 (rightmost).
- tens  input  4  BCD digit 1.
- hundreds  input  4  BCD digit 2.
- thousands  input  4  BCD digit 3 (leftmost).
- blink_mask  input  4  bit i set: digit i blinks.
- dp_mask  input  4  bit i set: decimal point of digit i lit.
- blank_lz  input  1  blank digit 3 when its snapshot value is 0.
- an  output  4  anode enables, active-low; an[i] selects digit i.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low.

## Operation
- **Prescaler.** Counts 0..REFRESH_DIV-1 and wraps. Its terminal count advances slot 0→1→2→3→0.
- **Blink counter.** Counts 0..BLINK_DIV-1. At terminal count it toggles `phase`.
- **Snapshot register.** Holds all four digits plus blink_mask, dp_mask and blank_lz. It loads:
  - at the edge where slot==3 and the prescaler is at terminal count (frame boundary), and
  - on the first edge after reset deasserts.
- Digit inputs are never used directly. This keeps one frame self-consistent even if the upstream stage updates mid-frame.
- **Output register.** Computed from the current slot, the snapshot and `phase`:
  - `an`: one-hot low at bit `slot`. All ones if the digit is blanked.
  - `seg`: decoded pattern for 0–9. Codes 10–15 show "-" (only g lit, seg=7'b0111111).
  - `dp`: low iff dp_mask[slot] and the digit is not blanked.
- **Blanking.** A digit is blanked when either condition holds:
  - phase==1 and blink_mask[slot]==1, or
  - slot==3, blank_lz==1 and the thousands snapshot==0.
- A blanked digit drives an=4'b1111, seg=7'h7F, dp=1.
- Only digit 3 is subject to leading-zero blanking.

## Timing
- **Reset values** (held while reset is high):
  - an=4'b1111, seg=7'h7F, dp=1.
  - slot=0, prescaler=0, blink counter=0, phase=0, snapshot all zero.
- **Startup.** Edge 1 after reset deasserts loads the snapshot with slot=0. Edge 2 outputs show slot 0 with the new snapshot.
- **Pipeline.** Outputs lag slot/snapshot state by exactly one clock. An anode change and its segment pattern change in the same cycle, so there is no ghost mix.
- **Dwell.** Each digit is lit for REFRESH_DIV cycles. A frame is 4·REFRESH_DIV cycles.
- **Input-to-display latency.** At most 4·REFRESH_DIV+2 cycles after an input change.
- **Simultaneous terminal counts.** Prescaler and blink terminal counts in the same cycle are both applied. The new phase affects outputs from the next output update.
- **Reset mid-frame.** Reset asserted during any slot forces reset values on the next edge. Deasserting restarts from slot 0 with a fresh snapshot.
- **Counter widths.** `$clog2(DIV)` bits each. Counters wrap, never saturate.

## Structure
- **Shared package `disp_pkg`:**
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - anode codes AN_OFF and AN_SEL[0..3];
  - slot typedef (2-bit).
- **Sub-module `seg_decode`:** purely combinational, 4-bit code → 7-bit active-low pattern. Instantiated once and fed the digit selected by slot.
- Everything else (counters, snapshot, output register) stays in `seg_scan`.

## Test plan
Sim parameters for all scenarios: REFRESH_DIV=4, BLINK_DIV=32.

1. **Reset.** Hold reset 3 cycles → an=1111, seg=7F, dp=1. Release → edge 2 shows an=1110; then 1101/1011/0111 every 4 cycles; frame repeats every 16 cycles.
2. **Decode and snapshot.** Digits 1,2,3,4 (ones..thousands) → seg patterns for 1,2,3,4 on an=1110,1101,1011,0111. Change ones to 9 mid-slot 2 → 9 appears only after the next frame boundary.
3. **Non-BCD code.** thousands=4'hC → seg=0111111 ("-") during slot 3.
4. **Leading-zero blanking.** thousands=0, blank_lz=1 → an=1111 during slot 3. With blank_lz=0 → an=0111, seg=SEG_0.
5. **Blink.** blink_mask=0011 → slots 0–1 dark for 32 cycles and lit for 32, alternating. Slots 2–3 are always lit.
6. **Decimal point and mid-frame reset.** dp_mask=0100 → dp=0 only with an=1011. Assert reset during slot 2 → reset values next edge; restart at slot 0.
